// File: rtl/inst_sequencer.sv
// Byte-serial program loader and replay sequencer feeding the 16-bit
// instruction port of tt_um_processor, with optional multi-pass looping.
module inst_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    load_data,
    input  logic          load_valid,
    input  logic          clear,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    loop_count,
    input  logic          inst_ready,
    output logic [15:0]   inst,
    output logic          inst_valid,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic          overflow
);

    // state   | meaning
    // S_IDLE  | loading / clearing allowed, waiting for start
    // S_RUN   | replaying buffer to downstream
    // S_DONE  | final instruction accepted; emits done on exit
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0]   FULL_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [15:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] prog_len_q, prog_len_d;
    logic        phase_q, phase_d;
    logic [7:0]  stage_q, stage_d;
    logic [3:0]  pass_q, pass_d;
    logic [15:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic        mem_we;
    logic        last_slot;

    assign last_slot = ({1'b0, rd_ptr_q} + LEN_ONE) == prog_len_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        prog_len_d   = prog_len_q;
        phase_d      = phase_q;
        stage_d      = stage_q;
        pass_d       = pass_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        mem_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (prog_len_q != '0) && !phase_q) begin
                    state_d  = S_RUN;
                    rd_ptr_d = '0;
                    pass_d   = loop_count;
                end else if (clear) begin
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                    phase_d    = 1'b0;
                    overflow_d = 1'b0;
                end else if (load_valid) begin
                    if (prog_len_q == FULL_LEN) begin
                        overflow_d = 1'b1;
                    end else if (!phase_q) begin
                        stage_d = load_data;
                        phase_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        prog_len_d = prog_len_q + LEN_ONE;
                        phase_d    = 1'b0;
                    end
                end
            end
            S_RUN: begin
                // First cycle of RUN has nothing presented yet: fetch slot 0.
                if (abort) begin
                    state_d      = S_IDLE;
                    inst_valid_d = 1'b0;
                end else if (!inst_valid_q) begin
                    inst_d       = mem[rd_ptr_q];
                    inst_valid_d = 1'b1;
                end else if (inst_ready) begin
                    if (!last_slot) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        inst_d   = mem[rd_ptr_q + PTR_ONE];
                    end else if (pass_q != 4'd0) begin
                        pass_d   = pass_q - 4'd1;
                        rd_ptr_d = '0;
                        inst_d   = mem[0];
                    end else begin
                        inst_valid_d = 1'b0;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            prog_len_q   <= '0;
            phase_q      <= 1'b0;
            stage_q      <= '0;
            pass_q       <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            prog_len_q   <= prog_len_d;
            phase_q      <= phase_d;
            stage_q      <= stage_d;
            pass_q       <= pass_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Buffer contents survive reset so only the pointers need clearing.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= {load_data, stage_q};
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign prog_len   = prog_len_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: per-cycle vector table plus hand-written
// sequences for overflow, abort and asynchronous reset.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  load_data;
    logic        load_valid, clear, start, abort, inst_ready;
    logic [3:0]  loop_count;
    logic [15:0] inst;
    logic        inst_valid, busy, done, overflow;
    logic [3:0]  prog_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_sequencer #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .clear(clear), .start(start), .abort(abort), .loop_count(loop_count),
        .inst_ready(inst_ready), .inst(inst), .inst_valid(inst_valid),
        .busy(busy), .done(done), .prog_len(prog_len), .overflow(overflow)
    );

    typedef struct {
        logic        lv;
        logic [7:0]  d;
        logic        st;
        logic        clr;
        logic [3:0]  lc;
        logic        rdy;
        logic [15:0] e_inst;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_len;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic lv, input logic [7:0] d, input logic st, input logic clr,
                       input logic [3:0] lc, input logic rdy, input logic [15:0] e_inst,
                       input logic e_valid, input logic e_busy, input logic e_done,
                       input logic [3:0] e_len, input logic e_ovf);
        vec_t v;
        v = '{lv, d, st, clr, lc, rdy, e_inst, e_valid, e_busy, e_done, e_len, e_ovf};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0; load_data = 8'h00; clear = 1'b0; start = 1'b0;
        abort = 1'b0; loop_count = 4'd0; inst_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset inst",     32'(inst), 32'h0);
        chk("reset valid",    32'(inst_valid), 0);
        chk("reset busy",     32'(busy), 0);
        chk("reset done",     32'(done), 0);
        chk("reset prog_len", 32'(prog_len), 0);
        chk("reset overflow", 32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;

        //   lv  data  st clr lc rdy  inst     vld bsy dne len ovf
        // single pass
        add(1, 8'h1B, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
        add(1, 8'h20, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 0);
        add(1, 8'h33, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 0);
        add(1, 8'h45, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 2, 0);
        add(0, 8'h00, 1, 0, 0, 1, 16'h0000, 0, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h201B, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 1, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        // three passes, valid continuous for six cycles
        add(0, 8'h00, 1, 0, 2, 1, 16'h4533, 0, 1, 0, 2, 0);
        for (int p = 0; p < 3; p++) begin
            add(0, 8'h00, 0, 0, 0, 1, 16'h201B, 1, 1, 0, 2, 0);
            add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 1, 1, 0, 2, 0);
        end
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 1, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        // backpressure on the first instruction
        add(0, 8'h00, 1, 0, 0, 0, 16'h4533, 0, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 0, 16'h201B, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 0, 16'h201B, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 0, 16'h201B, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 0, 16'h201B, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 1, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        // odd byte count blocks start; clear beats load
        add(1, 8'h99, 0, 1, 0, 1, 16'h4533, 0, 0, 0, 0, 0);
        add(1, 8'h11, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 0, 0);
        add(1, 8'h22, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 1, 0);
        add(1, 8'h33, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 1, 0);
        add(0, 8'h00, 1, 0, 0, 1, 16'h4533, 0, 0, 0, 1, 0);
        add(1, 8'h44, 0, 0, 0, 1, 16'h4533, 0, 0, 0, 2, 0);
        add(1, 8'h77, 1, 0, 0, 1, 16'h4533, 0, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h2211, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4433, 1, 1, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4433, 0, 0, 0, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4433, 0, 0, 1, 2, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            load_valid = tbl[i].lv;  load_data  = tbl[i].d;
            start      = tbl[i].st;  clear      = tbl[i].clr;
            loop_count = tbl[i].lc;  inst_ready = tbl[i].rdy;
            step();
            chk($sformatf("row%0d inst", i),  32'(inst),       32'(tbl[i].e_inst));
            chk($sformatf("row%0d valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d busy", i),  32'(busy),       32'(tbl[i].e_busy));
            chk($sformatf("row%0d done", i),  32'(done),       32'(tbl[i].e_done));
            chk($sformatf("row%0d len", i),   32'(prog_len),   32'(tbl[i].e_len));
            chk($sformatf("row%0d ovf", i),   32'(overflow),   32'(tbl[i].e_ovf));
        end
        idle_inputs();
        step();

        // overflow: 17 bytes into 8 slots
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 17; i++) begin
            load_valid = 1'b1; load_data = 8'(i);
            step();
        end
        load_valid = 1'b0;
        chk("full prog_len", 32'(prog_len), 8);
        chk("full overflow", 32'(overflow), 1);
        start = 1'b1; step(); start = 1'b0;
        chk("full launch busy", 32'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("full slot%0d inst", k), 32'(inst), 32'({8'(2*k+1), 8'(2*k)}));
            chk($sformatf("full slot%0d valid", k), 32'(inst_valid), 1);
        end
        step();
        chk("full end valid", 32'(inst_valid), 0);
        step();
        chk("full done", 32'(done), 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear prog_len", 32'(prog_len), 0);
        chk("clear overflow", 32'(overflow), 0);
        start = 1'b1; step(); start = 1'b0;
        chk("empty start busy", 32'(busy), 0);
        step();
        chk("empty start valid", 32'(inst_valid), 0);

        // abort on the second of four instructions
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1; load_data = 8'(8'hA0 + i);
            step();
        end
        load_valid = 1'b0;
        chk("abort prog_len", 32'(prog_len), 4);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("abort slot0", 32'(inst), 32'h0A1A0);
        step();
        chk("abort slot1", 32'(inst), 32'h0A3A2);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort valid", 32'(inst_valid), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        step();
        chk("abort no done", 32'(done), 0);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("restart slot0", 32'(inst), 32'h0A1A0);
        chk("restart valid", 32'(inst_valid), 1);

        // asynchronous reset mid-run
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(inst_valid), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst len", 32'(prog_len), 0);
        chk("async rst inst", 32'(inst), 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("post rst start ignored", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Upstream feeder for the 16-bit instruction port of tt_um_processor.
- Accepts a short program byte-serially and stores it in a small instruction buffer.
- Replays the program one instruction per accepted handshake, optionally looping a fixed number of passes.
- Output inst[15:0] maps directly onto the processor's {uio_in, ui_in} instruction bus. Low byte holds opcode/func; high byte holds register fields.

Parameters:
DEPTH, 8, number of 16-bit instruction slots (power of two)
AW, 3, pointer width, log2(DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high; clears all state
load_data  in  8  program byte; low byte of an instruction first, then high byte
load_valid  in  1  load_data valid this cycle
clear  in  1  empties buffer (IDLE only)
start  in  1  begin replay (IDLE only)
abort  in  1  terminate replay immediately
loop_count  in  4  extra passes; sampled at start, 0 = single pass
inst_ready  in  1  downstream accepts inst this cycle
inst  out  16  current instruction
inst_valid  out  1  inst is valid
busy  out  1  state is RUN
done  out  1  one-cycle pulse after the final instruction is accepted
prog_len  out  AW+1  number of complete instructions stored (0..DEPTH)
overflow  out  1  sticky: a byte was dropped because the buffer was full

Behaviour:
- Reset (async, rst=1): state=IDLE; inst=0, inst_valid=0, busy=0, done=0, prog_len=0, overflow=0; wr_ptr, rd_ptr, byte phase and pass counter=0. Buffer contents are not reset.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, load path, on load_valid:
  - phase=0: capture load_data in the low staging register; phase becomes 1.
  - phase=1: write {load_data, staged_low} to mem[wr_ptr]; wr_ptr+1; prog_len+1; phase becomes 0.
  - prog_len==DEPTH and load_valid: byte dropped, phase unchanged, overflow set to 1 and held.
- IDLE, clear: wr_ptr=0, prog_len=0, phase=0, overflow=0. Clear takes priority over load_valid in the same cycle.
- IDLE, start: accepted only when prog_len>0 and phase==0; otherwise ignored, with no state change. On acceptance:
  - state=RUN; rd_ptr=0; pass counter=loop_count.
  - Next edge: inst=mem[0], inst_valid=1.
  - start has priority over load_valid and clear in the same cycle; a coincident byte is dropped (overflow not set).
- RUN: inst/inst_valid hold stable while inst_ready=0. On each edge with inst_valid&&inst_ready:
  - Not the last slot (rd_ptr<prog_len-1): rd_ptr+1; inst=mem[rd_ptr+1] on the same edge. No bubble cycles.
  - Last slot, pass counter>0: pass counter-1; rd_ptr=0; inst=mem[0] (wrap-around, no bubble).
  - Last slot, pass counter==0: inst_valid=0; state=DONE.
- Total instructions issued = prog_len*(loop_count+1).
- load_valid, clear and start are ignored outside IDLE.
- DONE: done=1 for exactly one cycle, then IDLE. The program is retained, so a later start replays it.
- abort in RUN: next edge state=IDLE, inst_valid=0, done stays 0. Abort beats a same-cycle handshake (that instruction counts as accepted downstream, but nothing further is issued). Abort is ignored in other states.
- busy=1 exactly while state==RUN.
- rst asserted mid-RUN: outputs drop to reset values immediately (asynchronous), prog_len=0.

Test Plan:
- Load bytes 0x1B,0x20,0x33,0x45 with inst_ready=1, then start with loop_count=0 -> prog_len=2. One cycle after start: inst=0x201B, valid; next cycle inst=0x4533; next cycle valid=0; following cycle done=1 pulse; then busy=0.
- Same program, loop_count=2, inst_ready=1 -> inst sequence 0x201B,0x4533 repeated 3 times with inst_valid continuously high for 6 cycles; single done pulse.
- Backpressure: inst_ready=0 for 3 cycles while inst=0x201B -> inst and inst_valid stable. Raise inst_ready -> 0x4533 follows on the next edge.
- Load 17 bytes into DEPTH=8 -> prog_len=8, overflow=1. Start replays 8 instructions. clear -> prog_len=0, overflow=0. Start with prog_len=0 -> ignored, busy stays 0.
- Abort on the 2nd instruction of a 4-instruction program -> next edge inst_valid=0, busy=0, no done pulse. Restart -> sequence begins at slot 0.
- Odd byte count (3 bytes) then start -> ignored. 4th byte then start -> accepted. rst pulsed during RUN -> immediately inst_valid=0, busy=0, prog_len=0.
